// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and a show-ahead receive FIFO
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> one even-parity bit is expected between data bit 7 and the stop bit
//   undefined -> 10-bit frames, parity_err tied to 0
//
// Parameters: SYS_CLK_FREQ (Hz), BAUD_RATE (bit/s), FIFO_ADDR_WIDTH (depth = 2**FIFO_ADDR_WIDTH)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   rd_en      in   pop the head byte (ignored while empty)
//   rd_data    out  head byte of the FIFO, valid while empty=0
//   empty      out  FIFO holds no bytes
//   full       out  FIFO holds 2**FIFO_ADDR_WIDTH bytes
//   frame_err  out  sticky, stop bit sampled low
//   overrun    out  sticky, good byte dropped on a full FIFO
//   parity_err out  sticky, even-parity mismatch
//   err_clr    in   synchronous clear of all sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int SYS_CLK_FREQ    = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    input  logic       err_clr
);
    localparam int DIV   = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = 1;

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_fifo: SYS_CLK_FREQ/(BAUD_RATE*16) must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic          start_det;
    logic [3:0]    tc;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          push;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          pop;
    logic          wr;

    // Two-flop synchronizer; resets to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Oversampling tick; realigned to the falling edge of a start bit.
    assign start_det = (state == IDLE) && !rxs;
    assign tick      = (div_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else
            div_cnt <= (start_det || tick) ? '0 : div_cnt + CW'(1);
    end

    // Receive FSM. START waits half a bit (8 ticks) to land mid-bit; every later
    // sample is 16 ticks apart. push is a one-cycle strobe after a good stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tc        <= '0;
            idx       <= '0;
            shift     <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            push <= 1'b0;
            if (err_clr) begin
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        tc    <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tc == 4'd7) begin
                            state <= rxs ? IDLE : DATA;
                            tc    <= '0;
                            idx   <= '0;
                        end else begin
                            tc <= tc + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tc <= tc + 4'd1;
                        if (tc == 4'd15) begin
                            shift <= {rxs, shift[7:1]};
                            idx   <= idx + 3'd1;
                            if (idx == 3'd7)
                                state <= AFTER_DATA;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tc <= tc + 4'd1;
                        if (tc == 4'd15) begin
                            if (^shift ^ rxs)
                                parity_err <= 1'b1;
                            state <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        tc <= tc + 4'd1;
                        if (tc == 4'd15) begin
                            if (rxs) begin
                                push  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BRK;
                            end
                        end
                    end
                end
                BRK: begin
                    // Hold here until the line returns high so a long break yields no bytes.
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign pop     = rd_en && !empty;
    assign wr      = push && (!full || pop);
    assign rd_data = empty ? 8'h00 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr[AW-1:0]] <= shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + PTR_ONE;
            if (pop)
                rptr <= rptr + PTR_ONE;
            if (err_clr)
                overrun <= 1'b0;
            if (push && full && !pop)
                overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (DIV=1, 16 clk per bit)
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FB = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    // start edge -> empty falls: sync(2) + idle detect(1) + half bit(8) + remaining bits + push(1)
    localparam int LAT = 2 + 1 + 8 + 16 * (FB - 1) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, frame_err, overrun, parity_err;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         fall_cyc = -1;
    int         start = 0;
    logic       prev_empty = 1'b1;
    logic [7:0] q[$];
    logic       fe_m = 1'b0, ov_m = 1'b0, pe_m = 1'b0;
    logic [7:0] d;

    uart_rx_fifo #(
        .SYS_CLK_FREQ(1600000),
        .BAUD_RATE(100000),
        .FIFO_ADDR_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .empty(empty),
        .full(full),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (prev_empty === 1'b1 && empty === 1'b0)
            fall_cyc = cyc;
        prev_empty = empty;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
        if (q.size() != 0)
            check({tag, " rd_data"}, 32'(rd_data), 32'(q[0]));
        check({tag, " frame_err"}, 32'(frame_err), 32'(fe_m));
        check({tag, " overrun"}, 32'(overrun), 32'(ov_m));
        check({tag, " parity_err"}, 32'(parity_err), 32'(pe_m));
    endtask

    // Drives one frame; rd_at/clr_at pulse rd_en/err_clr for one clk at that bit-time offset.
    task automatic send_frame(input logic [7:0] fd, input logic stop_bit, input logic bad_par,
                              input int rd_at, input int clr_at);
        logic [FB-1:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, ^fd ^ bad_par, fd, 1'b0};
`else
        bits = {stop_bit, fd, 1'b0};
`endif
        for (int c = 0; c < 16 * FB; c++) begin
            if (c == rd_at && q.size() != 0) begin
                check("pushpop head", 32'(rd_data), 32'(q[0]));
                void'(q.pop_front());
            end
            rx = bits[c / 16];
            rd_en = (c == rd_at);
            err_clr = (c == clr_at);
            step();
        end
        rd_en = 1'b0;
        err_clr = 1'b0;
        if (clr_at >= 0) begin
            fe_m = 1'b0;
            ov_m = 1'b0;
            pe_m = 1'b0;
        end
        pe_m = pe_m | (PAR_EN & bad_par);
        if (!stop_bit)
            fe_m = 1'b1;
        else if (q.size() < DEPTH)
            q.push_back(fd);
        else
            ov_m = 1'b1;
    endtask

    task automatic pop_one(input string tag);
        check({tag, " empty"}, 32'(empty), 32'(0));
        if (q.size() != 0) begin
            check({tag, " data"}, 32'(rd_data), 32'(q[0]));
            void'(q.pop_front());
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        fe_m = 1'b0;
        ov_m = 1'b0;
        pe_m = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check_all("reset");
        check("reset rd_data", 32'(rd_data), 32'h0);
        rst_n = 1'b1;
        step();

        // Single byte: exact latency and contents
        fall_cyc = -1;
        start = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
        check("a5 latency", 32'(fall_cyc - start), 32'(LAT));
        check_all("a5");
        pop_one("a5 pop");
        check_all("a5 drained");

        // Short low pulse is rejected; receiver still works afterwards
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (30) step();
        check_all("glitch");
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0, -1, -1);
        check_all("after glitch");
        pop_one("after glitch pop");

        // Framing error with a long break
        send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
        repeat (40) step();
        rx = 1'b1;
        repeat (20) step();
        check_all("frame_err");
        clear_flags();
        check_all("err_clr");

        // Fill 0x00..0x08: 0x08 overflows
        for (int i = 0; i <= 8; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, -1, -1);
            if (i >= 7)
                check_all(i == 7 ? "fill8" : "overflow");
        end
        while (q.size() != 0)
            pop_one("fill drain");
        check_all("fill drained");
        clear_flags();

        // Push and pop in the same cycle while full
        for (int i = 0; i < DEPTH; i++)
            send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
        send_frame(8'h55, 1'b1, 1'b0, LAT - 1, -1);
        check_all("full pushpop");
        while (q.size() != 0)
            pop_one("full pushpop drain");
        check_all("full pushpop drained");

        // Sticky set beats err_clr in the same cycle
        for (int i = 0; i < DEPTH; i++)
            send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
        send_frame(8'($urandom), 1'b1, 1'b0, -1, LAT - 1);
        check_all("overrun set wins");
        send_frame(8'($urandom), 1'b0, 1'b0, -1, LAT - 2);
        rx = 1'b1;
        repeat (20) step();
        check_all("frame_err set wins");
        while (q.size() != 0)
            pop_one("set wins drain");
        clear_flags();

        // Push and pop in the same cycle with one entry
        send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
        send_frame(8'($urandom), 1'b1, 1'b0, LAT - 1, -1);
        check_all("one entry pushpop");

        // Asynchronous reset mid-frame, then the still-low line starts a new frame
        send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
        rx = 1'b1;
        repeat (20) step();
        check_all("pre reset");
        rx = 1'b0;
        repeat (70) step();
        rst_n = 1'b0;
        #1;
        q.delete();
        fe_m = 1'b0;
        ov_m = 1'b0;
        pe_m = 1'b0;
        check_all("async reset");
        check("async reset rd_data", 32'(rd_data), 32'h0);
        repeat (2) step();
        check_all("in reset");
        rst_n = 1'b1;
        fall_cyc = -1;
        start = cyc;
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0, -1, -1);
        check("post reset latency", 32'(fall_cyc - start), 32'(LAT));
        check_all("post reset");
        pop_one("post reset pop");

        // Random traffic with random reads and idle gaps
        for (int i = 0; i < 12; i++) begin
            send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
            repeat ($urandom_range(0, 5)) step();
            repeat ($urandom_range(0, 2))
                if (q.size() != 0)
                    pop_one("random pop");
        end
        check_all("random");
        while (q.size() != 0)
            pop_one("random drain");
        check_all("random drained");

`ifdef UART_RX_PARITY_EN
        clear_flags();
        send_frame(8'h07, 1'b1, 1'b1, -1, -1);
        check_all("parity bad");
        clear_flags();
        send_frame(8'h07, 1'b1, 1'b0, -1, -1);
        check_all("parity good");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
